// File: rtl/tpu_layer_sequencer.sv
// Sequences NUM_LAYERS fully-connected layer engines over a shared ROM/MultAdder bus,
// with start/abort handshake, per-layer watchdog and classifier result capture.
module tpu_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int LAYER_W    = 4,
    parameter int RESULT_W   = 4,
    parameter int TIMER_W    = 16
) (
    input  logic                  clk,
    input  logic                  iRst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TIMER_W-1:0]    timeout_limit,
    input  logic [NUM_LAYERS-1:0] layer_done,
    input  logic [RESULT_W-1:0]   class_in,
    output logic [NUM_LAYERS-1:0] layer_ena,
    output logic [NUM_LAYERS-1:0] layer_rstn,
    output logic [LAYER_W-1:0]    cur_layer,
    output logic                  busy,
    output logic [RESULT_W-1:0]   num_out,
    output logic                  done,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {S_IDLE, S_ENA, S_RUN, S_GAP, S_DONE, S_ERR} state_t;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               done_hit;
    logic               wd_expired;

    function automatic logic [NUM_LAYERS-1:0] onehot(input logic [LAYER_W-1:0] idx);
        return NUM_LAYERS'(1) << idx;
    endfunction

    // layer_ena is one-hot on cur_layer during RUN, so masking ignores done flags of idle engines
    always_comb begin
        done_hit   = |(layer_done & layer_ena);
        wd_expired = (timeout_limit != '0) && (timer == timeout_limit - TIMER_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state       <= S_IDLE;
            layer_ena   <= '0;
            layer_rstn  <= '0;
            cur_layer   <= '0;
            busy        <= 1'b0;
            num_out     <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else if (abort) begin
            state       <= S_IDLE;
            layer_ena   <= '0;
            layer_rstn  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state       <= S_ENA;
                        cur_layer   <= '0;
                        layer_ena   <= onehot(LAYER_W'(0));
                        layer_rstn  <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout_err <= 1'b0;
                        timer       <= '0;
                    end
                end
                S_ENA: begin
                    state      <= S_RUN;
                    layer_rstn <= layer_ena;
                    timer      <= '0;
                end
                S_RUN: begin
                    if (done_hit) begin
                        layer_ena  <= '0;
                        layer_rstn <= '0;
                        if (cur_layer == LAST_LAYER) begin
                            state   <= S_DONE;
                            num_out <= class_in;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (wd_expired) begin
                        state       <= S_ERR;
                        layer_ena   <= '0;
                        layer_rstn  <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        num_out     <= '1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                // one dead cycle on the shared bus before the next engine takes it
                S_GAP: begin
                    state      <= S_ENA;
                    cur_layer  <= cur_layer + LAYER_W'(1);
                    layer_ena  <= onehot(cur_layer + LAYER_W'(1));
                    layer_rstn <= '0;
                    timer      <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/tpu_layer_sequencer.md
Name: tpu_layer_sequencer

Overview:
- Parametrised successor of the fixed three-layer TPU controller.
- Sequences NUM_LAYERS fully-connected layer engines that share one ROM and one MultAdder. It drives a one-hot enable and a per-layer active-low reset to the engines and waits for each engine's done.
- After the last layer it captures the classifier index from the max-of-N unit. It adds a start/abort handshake, per-layer watchdog timeout, progress/status outputs and restart without global reset.

Parameters:
- NUM_LAYERS, 3, number of layer engines sequenced (1..16).
- LAYER_W, 4, width of the layer index; must satisfy 2^LAYER_W >= NUM_LAYERS.
- RESULT_W, 4, width of the classifier index.
- TIMER_W, 16, width of the watchdog counter and limit.

Ports:
- clk, input, 1, clock; all logic on posedge.
- iRst_n, input, 1, synchronous active-low reset.
- start, input, 1, begin inference; sampled only in IDLE, DONE, ERR.
- abort, input, 1, soft stop; return to IDLE.
- timeout_limit, input, TIMER_W, maximum cycles per layer in RUN; 0 disables the watchdog.
- layer_done, input, NUM_LAYERS, done flags from the engines.
- class_in, input, RESULT_W, index from the max-of-N unit.
- layer_ena, output, NUM_LAYERS, one-hot engine enable; also the shared-bus mux select.
- layer_rstn, output, NUM_LAYERS, per-engine active-low reset.
- cur_layer, output, LAYER_W, index of the active or last layer.
- busy, output, 1, high from the cycle after start until DONE or ERR.
- num_out, output, RESULT_W, captured result.
- done, output, 1, level; high in DONE and ERR.
- timeout_err, output, 1, level; high in ERR.

Behaviour:
- Reset (iRst_n=0 at posedge): state=IDLE.
  - layer_ena=0, layer_rstn=0, cur_layer=0, busy=0, num_out=0, done=0, timeout_err=0, timer=0.
  - Reset has priority over abort and start.
- All outputs are registered. At most one layer_ena bit is high in any cycle. layer_rstn[i] is low whenever layer_ena[i] is low.
- States:
  - IDLE:
    - start=1 -> ENA with cur_layer=0, busy=1.
  - ENA:
    - layer_ena[cur_layer]=1, layer_rstn[cur_layer]=0 for exactly one cycle -> RUN.
  - RUN:
    - layer_rstn[cur_layer]=1, timer increments each cycle from 0.
    - layer_done[cur_layer] sampled high and cur_layer<NUM_LAYERS-1 -> GAP; clear all ena/rstn.
    - layer_done[cur_layer] sampled high and cur_layer==NUM_LAYERS-1 -> DONE; num_out<=class_in in the same edge, ena/rstn cleared.
    - Otherwise, if timeout_limit!=0 and timer==timeout_limit-1 -> ERR.
    - layer_done wins over timeout on the same edge.
    - layer_done bits of non-active layers are ignored.
  - GAP:
    - One idle cycle with all enables low (bus turnaround) -> ENA; cur_layer+1, timer=0.
  - DONE:
    - done=1, busy=0. Holds until start or abort.
    - start=1 -> ENA with cur_layer=0; done cleared at the same edge.
  - ERR:
    - done=1, timeout_err=1, busy=0, num_out set to all-ones, cur_layer frozen at the failing layer.
    - start=1 -> ENA with cur_layer=0; timeout_err and done cleared.
- abort=1 in any state -> IDLE next edge.
  - Clears ena/rstn/busy/done/timeout_err/timer.
  - num_out and cur_layer hold.
  - abort has priority over start.
- start while busy is ignored.
- Per-layer overhead: ENA 1 cycle + GAP 1 cycle.
  - With done latencies L_i (cycles in RUN up to and including the sampling edge), total latency from the start edge to done=1 is sum(L_i) + 2*NUM_LAYERS - 1 cycles.
- NUM_LAYERS=1: no GAP is ever entered.

Test Plan:
- Basic run, NUM_LAYERS=3, timeout_limit=0, each engine raises done 5 cycles into RUN, class_in=7 -> ena sequence 001,010,100 with one all-zero GAP between layers. rstn low only in each ENA cycle. done=1 at 20 cycles after start. num_out=7, timeout_err=0.
- Timeout, timeout_limit=8, layer 1 never signals done -> ERR after 8 RUN cycles in layer 1. timeout_err=1, done=1, cur_layer=1, num_out=4'hF, all ena low.
- Done/timeout tie, timeout_limit=6, layer_done[0] asserted on the 6th RUN cycle -> proceeds to GAP, no error.
- Abort mid-layer 2 -> next cycle layer_ena=0, busy=0, done=0, cur_layer=2. A following start runs the full sequence from layer 0.
- Restart and noise: after DONE with num_out=3, pulse start with class_in=9 -> done drops at the start edge and the second result is 9. A layer_done pulse on a non-active layer and a start pulse during RUN cause no change.
- Sync reset during RUN of layer 1 -> all outputs zero on the next edge. Asserting iRst_n low without a clock edge has no effect.
